// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage and its IF/ID consumer:
//   fetch_state_e  - fetch FSM states
//   DEF_NOP_INST   - instruction presented while no valid fetch is buffered
//   if_packet_t    - IF/ID payload {valid, pc, npc, inst}
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    localparam int unsigned PKG_XLEN     = 32;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // free to issue a request
        S_WAIT = 2'd1,   // one granted request outstanding
        S_KILL = 2'd2    // outstanding request is stale, drop its response
    } fetch_state_e;

    typedef struct packed {
        logic                valid;
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] npc;
        logic [31:0]         inst;
    } if_packet_t;

endpackage

// File: rtl/if_fetch_stage_chk.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_chk
// Protocol checker for the fetch stage memory port.
// Ports: clock, reset, state (fetch FSM state), imem_req, imem_gnt, imem_rvalid.
// A response arriving while the FSM is idle is an error, except for one left
// over from a transaction that reset cut short (tolerated until next grant).
// -----------------------------------------------------------------------------
module if_fetch_stage_chk
    import if_fetch_stage_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  fetch_state_e state,
    input  logic         imem_req,
    input  logic         imem_gnt,
    input  logic         imem_rvalid
);

    logic orphan_ok_r;

    // Set by reset, cleared by the first grant after it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            orphan_ok_r <= 1'b1;
        end else if (imem_req && imem_gnt) begin
            orphan_ok_r <= 1'b0;
        end else begin
            orphan_ok_r <= orphan_ok_r;
        end
    end

    rvalid_only_when_owed: assert property (
        @(posedge clock) disable iff (!reset)
        (imem_rvalid && (state == S_REQ)) |-> orphan_ok_r
    );

endmodule

// File: rtl/if_inst_buf.sv
// -----------------------------------------------------------------------------
// if_inst_buf
// One-entry holding buffer between instruction memory and IF/ID.
// Ports:
//   clock, reset       - clock, async active-low reset
//   load               - capture {load_pc, load_inst}
//   consume            - IF/ID takes the entry this edge
//   flush              - drop the entry (branch redirect)
//   load_pc, load_inst - data to capture
//   valid, pc, npc, inst - registered entry; inst is the NOP while !valid
// Priority: flush > load > consume, so a reload at the consuming edge wins.
// -----------------------------------------------------------------------------
module if_inst_buf
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}},
    parameter logic [31:0]      NOP_INST = DEF_NOP_INST
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            consume,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_inst,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic [31:0]     inst
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] npc_r;
    logic [31:0]     inst_r;

    // Entry register; npc is kept registered so every output comes from a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            pc_r    <= RESET_PC;
            npc_r   <= RESET_PC + PC_STEP;
            inst_r  <= NOP_INST;
        end else if (flush) begin
            valid_r <= 1'b0;
            inst_r  <= NOP_INST;
        end else if (load) begin
            valid_r <= 1'b1;
            pc_r    <= load_pc;
            npc_r   <= load_pc + PC_STEP;
            inst_r  <= load_inst;
        end else if (consume) begin
            valid_r <= 1'b0;
            inst_r  <= NOP_INST;
        end else begin
            valid_r <= valid_r;
            pc_r    <= pc_r;
            npc_r   <= npc_r;
            inst_r  <= inst_r;
        end
    end

    assign valid = valid_r;
    assign pc    = pc_r;
    assign npc   = npc_r;
    assign inst  = inst_r;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch: owns the PC, issues one instruction-memory request at a
// time, yields the shared port to MEM, buffers the returned instruction until
// IF/ID accepts it and squashes in-flight fetches on a taken branch.
// Ports:
//   clock, reset                  - clock, async active-low reset
//   if_id_enable                  - IF/ID latches this cycle
//   has_structure_hazard          - MEM stage owns the memory port
//   branch_taken, branch_target   - redirect from EX
//   imem_req/addr/gnt             - request channel (req is combinational)
//   imem_rvalid/rdata             - response channel
//   if_valid/pc/npc/inst          - buffered instruction towards IF/ID
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INST = DEF_NOP_INST
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_id_enable,
    input  logic            has_structure_hazard,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_npc,
    output logic [31:0]     if_inst
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    fetch_state_e    state_r;
    fetch_state_e    state_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_s;
    logic [XLEN-1:0] target_s;
    logic            buf_load_s;
    logic            buf_valid_s;

    assign target_s  = {branch_target[XLEN-1:2], 2'b00};
    assign imem_addr = pc_r;

    // Request only when the buffer is free by the next edge; held low in reset.
    always_comb begin
        imem_req = 1'b0;
        if (reset && (state_r == S_REQ) && !has_structure_hazard && !branch_taken &&
            (!buf_valid_s || if_id_enable)) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    // Next state / next PC; a redirect overrides everything else.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        buf_load_s = 1'b0;
        if (branch_taken) begin
            pc_s = target_s;
            case (state_r)
                S_REQ:   state_s = S_REQ;
                S_WAIT:  state_s = imem_rvalid ? S_REQ : S_KILL;
                S_KILL:  state_s = imem_rvalid ? S_REQ : S_KILL;
                default: state_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        state_s = S_WAIT;
                    end else begin
                        state_s = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        buf_load_s = 1'b1;
                        pc_s       = pc_r + PC_STEP;
                        state_s    = S_REQ;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_KILL: begin
                    if (imem_rvalid) begin
                        state_s = S_REQ;
                    end else begin
                        state_s = S_KILL;
                    end
                end
                default: state_s = S_REQ;
            endcase
        end
    end

    // FSM state and fetch PC registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
        end
    end

    if_inst_buf #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .load      (buf_load_s),
        .consume   (if_id_enable),
        .flush     (branch_taken),
        .load_pc   (pc_r),
        .load_inst (imem_rdata),
        .valid     (buf_valid_s),
        .pc        (if_pc),
        .npc       (if_npc),
        .inst      (if_inst)
    );

    assign if_valid = buf_valid_s;

    if_fetch_stage_chk u_chk (
        .clock       (clock),
        .reset       (reset),
        .state       (state_r),
        .imem_req    (imem_req),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Randomised bench for if_fetch_stage. A memory model answers grants after a
// random latency; a reference model tracks the architectural fetch stream
// (sequential PCs, restarted by redirects and reset) and queues the
// instructions IF/ID should see; a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_id_enable = 1'b0;
    logic        has_structure_hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0000_0000;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic [31:0] if_inst;

    if_fetch_stage dut (
        .clock                (clock),
        .reset                (reset),
        .if_id_enable         (if_id_enable),
        .has_structure_hazard (has_structure_hazard),
        .branch_taken         (branch_taken),
        .branch_target        (branch_target),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_gnt             (imem_gnt),
        .imem_rvalid          (imem_rvalid),
        .imem_rdata           (imem_rdata),
        .if_valid             (if_valid),
        .if_pc                (if_pc),
        .if_npc               (if_npc),
        .if_inst              (if_inst)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [31:0] next_pc = RESET_PC;
    logic        owed = 1'b0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0000_0000;
    int          mem_cnt = 0;
    int          max_delay = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, driven just after the rising edge.
    task automatic drive_cycle(input int p_gnt, input int p_en, input int p_haz, input int p_br);
        @(posedge clock);
        #1;
        if (mem_pend && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_pend    = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_pend) mem_cnt--;
        end
        imem_gnt             = roll(p_gnt);
        if_id_enable         = roll(p_en);
        has_structure_hazard = roll(p_haz);
        branch_taken         = roll(p_br);
        case ($urandom_range(3))
            0:       branch_target = 32'h0000_0100;
            1:       branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            default: branch_target = $urandom;
        endcase
    endtask

    task automatic check_reset_outputs();
        @(negedge clock);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, RESET_PC);
        chk("rst_if_npc", if_npc, RESET_PC + 32'd4);
        chk("rst_if_inst", if_inst, NOP);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
    endtask

    // Monitor: whatever IF presents must be the head of the expected stream.
    always @(negedge clock) begin
        if (reset) begin
            chk("if_valid", {31'd0, if_valid}, {31'd0, (exp_q.size() > 0)});
            if (if_valid && exp_q.size() > 0) begin
                chk("if_pc", if_pc, exp_q[0].pc);
                chk("if_npc", if_npc, exp_q[0].pc + 32'd4);
                chk("if_inst", if_inst, exp_q[0].inst);
                if (if_id_enable) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end else if (!if_valid) begin
                chk("if_inst_nop", if_inst, NOP);
            end
        end
    end

    // Reference model and memory grant capture, after the monitor has run.
    always begin
        logic exp_req;
        @(negedge clock);
        #1;
        if (!reset) begin
            exp_q.delete();
            next_pc = RESET_PC;
            owed    = 1'b0;
        end else begin
            exp_req = !mem_pend && !imem_rvalid && !has_structure_hazard && !branch_taken &&
                      (exp_q.size() == 0 || if_id_enable);
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            if (branch_taken) begin
                exp_q.delete();
                next_pc = branch_target & 32'hFFFF_FFFC;
                owed    = 1'b0;
            end else if (imem_rvalid && owed) begin
                exp_q.push_back('{next_pc, mem_word(next_pc)});
                next_pc = next_pc + 32'd4;
                owed    = 1'b0;
            end
            if (imem_req && imem_gnt) begin
                chk("imem_addr", imem_addr, next_pc);
                owed     = 1'b1;
                mem_pend = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = $urandom_range(max_delay);
            end
        end
    end

    initial begin
        logic hit;
        repeat (3) @(negedge clock);
        check_reset_outputs();
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single-cycle memory, IF/ID always accepting.
        max_delay = 0;
        repeat (20) drive_cycle(100, 100, 0, 0);

        // Random traffic with stalls, hazards and redirects.
        max_delay = 3;
        repeat (1500) drive_cycle(60, 70, 20, 5);

        // Redirect near the top of the address space, then wrap to zero.
        drive_cycle(100, 100, 0, 0);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFF5;
        repeat (20) drive_cycle(100, 100, 0, 0);

        // Reset while a request is outstanding; its late response is ignored.
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            drive_cycle(100, 100, 0, 0);
            @(negedge clock);
            #2;
            hit = mem_pend;
        end
        chk("reach_wait", {31'd0, hit}, 32'd1);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        imem_rvalid  = 1'b0;
        imem_gnt     = 1'b0;
        branch_taken = 1'b0;
        check_reset_outputs();
        @(posedge clock);
        #1;
        reset                = 1'b1;
        imem_rvalid          = 1'b1;
        imem_rdata           = mem_word(mem_addr);
        mem_pend             = 1'b0;
        imem_gnt             = 1'b0;
        has_structure_hazard = 1'b1;
        branch_taken         = 1'b0;
        repeat (500) drive_cycle(60, 70, 20, 5);

        // Drain.
        repeat (12) drive_cycle(100, 100, 0, 0);
        @(negedge clock);
        chk("min_deliveries", {31'd0, (delivered >= 100)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID register and the hazard detection unit. It owns the PC and issues one instruction-memory request at a time over the shared memory port. It yields the port whenever the MEM stage holds it (has_structure_hazard). It buffers the returned instruction until IF/ID accepts it (if_id_enable), and squashes in-flight fetches on a taken-branch redirect.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, instruction driven on if_inst while if_valid=0 (addi x0,x0,0)

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
if_id_enable  in  1  from hazard unit; 1 = IF/ID latches this cycle
has_structure_hazard  in  1  from hazard unit; 1 = MEM stage owns memory port this cycle
branch_taken  in  1  redirect from EX; squash and refetch
branch_target  in  XLEN  redirect PC
imem_req  out  1  request valid
imem_addr  out  XLEN  request address (current PC, word aligned)
imem_gnt  in  1  request accepted this cycle (sampled with imem_req)
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction
if_valid  out  1  buffered instruction valid
if_pc  out  XLEN  PC of buffered instruction
if_npc  out  XLEN  if_pc + 4 (modulo 2^XLEN)
if_inst  out  32  buffered instruction, NOP_INST when if_valid=0

Behaviour:
- Reset (async assert, sync deassert): fetch PC=RESET_PC; state=S_REQ; buf_valid=0; if_pc=RESET_PC; if_inst=NOP_INST; imem_req=0. Reset mid-transaction drops any outstanding response: after reset, rvalid is ignored until a new grant.
- State machine:
  - S_REQ: issuing.
  - S_WAIT: one granted request outstanding.
  - S_KILL: outstanding request is stale; its response is discarded.
- imem_req is combinational: state==S_REQ && !has_structure_hazard && !branch_taken && (!buf_valid || if_id_enable). The last term means a new fetch only starts when the buffer will be free. imem_addr = fetch PC.
- Request/grant does not need to stay stable: imem_req may drop before grant; only the cycle with imem_req&&imem_gnt counts.
- S_REQ, imem_req && imem_gnt -> S_WAIT.
- S_WAIT, imem_rvalid, no branch:
  - buffer <= {fetch PC, imem_rdata}, buf_valid=1;
  - fetch PC += 4;
  - state -> S_REQ.
  - The next request is issued from the following cycle (≥2 cycles/instruction).
- Buffer consumption: at an edge with if_id_enable && buf_valid, buf_valid clears unless reloaded at the same edge (reload wins). With if_id_enable=0, if_valid/if_pc/if_inst hold stable.
- Branch redirect (priority over everything else): buf_valid <= 0; fetch PC <= branch_target.
  - S_REQ -> S_REQ (no request is issued while branch_taken is high).
  - S_WAIT without rvalid -> S_KILL.
  - S_WAIT with rvalid same cycle -> response dropped, -> S_REQ.
  - S_KILL with rvalid same cycle -> S_REQ; otherwise stay S_KILL with the updated PC.
- S_KILL, rvalid -> discard data, -> S_REQ. No buffer update.
- imem_rvalid in S_REQ is a protocol error: ignored; simulation assertion fires.
- Arithmetic: PC+4 wraps modulo 2^XLEN. branch_target[1:0] is forced to 0.

Decomposition:
- Shared package (pipeline pkg): fetch_state_e {S_REQ, S_WAIT, S_KILL}; NOP_INST constant; if_packet_t struct {valid, pc, npc, inst} as the IF/ID payload.
- One sub-module, if_inst_buf: one-entry buffer with load/consume/flush and the NOP default. The FSM and PC logic stay in the top module.

Test Plan:
- Reset then 1-cycle memory (gnt same cycle, rvalid next), if_id_enable=1 -> instructions at PC 0,4,8 appear with if_valid every 2 cycles; if_npc=4,8,12.
- if_id_enable=0 for 5 cycles with buffer full -> if_pc/if_inst hold; imem_req=0; no PC advance; release -> next fetch at +4.
- has_structure_hazard=1 for 3 cycles in S_REQ -> imem_req=0 those cycles; request issues on cycle 4 with unchanged address.
- branch_taken (target 0x100) in S_WAIT, rvalid 2 cycles later -> stale response discarded; next imem_addr=0x100; if_valid first rises with if_pc=0x100.
- branch_taken and imem_rvalid same cycle -> response dropped, buf_valid=0, next request addr=target; branch at PC 0xFFFF_FFFC sequential -> next PC 0x0.
- Reset asserted while in S_WAIT, rvalid after deassert -> ignored; outputs at reset values; first request addr=RESET_PC.
